// File: rtl/rs_alu_pkg.sv
// Shared definitions for the ALU reservation station: opcode encodings, default widths, CDB fields.
// The optional age-ordered dispatch is enabled with the RS_AGE_SELECT_EN macro.
package rs_alu_pkg;

  localparam int ORDER_W     = 6;
  localparam int DATA_W      = 32;
  localparam int DEF_TAG_W   = 4;
  localparam int DEF_RS_SIZE = 8;

  // Common data bus bundle: valid, ROB tag, result value.
  localparam int CDB_TAG_W = DEF_TAG_W;
  localparam int CDB_VAL_W = DATA_W;

  localparam logic [ORDER_W-1:0] OP_NOP   = 6'd0;
  localparam logic [ORDER_W-1:0] OP_LUI   = 6'd1;
  localparam logic [ORDER_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [ORDER_W-1:0] OP_JAL   = 6'd3;
  localparam logic [ORDER_W-1:0] OP_JALR  = 6'd4;
  localparam logic [ORDER_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [ORDER_W-1:0] OP_BNE   = 6'd6;
  localparam logic [ORDER_W-1:0] OP_BLT   = 6'd7;
  localparam logic [ORDER_W-1:0] OP_BGE   = 6'd8;
  localparam logic [ORDER_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [ORDER_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [ORDER_W-1:0] OP_LB    = 6'd11;
  localparam logic [ORDER_W-1:0] OP_LH    = 6'd12;
  localparam logic [ORDER_W-1:0] OP_LW    = 6'd13;
  localparam logic [ORDER_W-1:0] OP_LBU   = 6'd14;
  localparam logic [ORDER_W-1:0] OP_LHU   = 6'd15;
  localparam logic [ORDER_W-1:0] OP_SB    = 6'd16;
  localparam logic [ORDER_W-1:0] OP_SH    = 6'd17;
  localparam logic [ORDER_W-1:0] OP_SW    = 6'd18;
  localparam logic [ORDER_W-1:0] OP_ADDI  = 6'd19;
  localparam logic [ORDER_W-1:0] OP_SLTI  = 6'd20;
  localparam logic [ORDER_W-1:0] OP_SLTIU = 6'd21;
  localparam logic [ORDER_W-1:0] OP_XORI  = 6'd22;
  localparam logic [ORDER_W-1:0] OP_ORI   = 6'd23;
  localparam logic [ORDER_W-1:0] OP_ANDI  = 6'd24;
  localparam logic [ORDER_W-1:0] OP_SLLI  = 6'd25;
  localparam logic [ORDER_W-1:0] OP_SRLI  = 6'd26;
  localparam logic [ORDER_W-1:0] OP_SRAI  = 6'd27;
  localparam logic [ORDER_W-1:0] OP_ADD   = 6'd28;
  localparam logic [ORDER_W-1:0] OP_SUB   = 6'd29;
  localparam logic [ORDER_W-1:0] OP_SLL   = 6'd30;
  localparam logic [ORDER_W-1:0] OP_SLT   = 6'd31;
  localparam logic [ORDER_W-1:0] OP_SLTU  = 6'd32;
  localparam logic [ORDER_W-1:0] OP_XOR   = 6'd33;
  localparam logic [ORDER_W-1:0] OP_SRL   = 6'd34;
  localparam logic [ORDER_W-1:0] OP_SRA   = 6'd35;
  localparam logic [ORDER_W-1:0] OP_OR    = 6'd36;
  localparam logic [ORDER_W-1:0] OP_AND   = 6'd37;

endpackage

// File: rtl/rs_alu_select.sv
// Slot pickers for the reservation station: lowest free slot for issue, one ready slot for dispatch.
// With RS_AGE_SELECT_EN the dispatch pick is the oldest ready slot according to the age matrix.
module rs_alu_select #(
  parameter int RS_SIZE = 8,
  parameter int IDX_W   = $clog2(RS_SIZE)
) (
  input  logic [RS_SIZE-1:0]              busy,
  input  logic [RS_SIZE-1:0]              ready,
`ifdef RS_AGE_SELECT_EN
  input  logic [RS_SIZE-1:0][RS_SIZE-1:0] age,
`endif
  output logic [IDX_W-1:0]                free_idx,
  output logic                            free_found,
  output logic [IDX_W-1:0]                disp_idx,
  output logic                            disp_found
);

  logic [RS_SIZE-1:0] cand;

`ifdef RS_AGE_SELECT_EN
  // age[j][i] set means slot j is older than slot i; keep only the ready slot nothing ready predates.
  always_comb begin
    cand = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      cand[i] = ready[i];
      for (int j = 0; j < RS_SIZE; j++) begin
        if (j != i && ready[j] && age[j][i]) cand[i] = 1'b0;
      end
    end
  end
`else
  assign cand = ready;
`endif

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    disp_idx   = '0;
    disp_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
      if (cand[i]) begin
        disp_idx   = IDX_W'(i);
        disp_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// Integer ALU reservation station: holds renamed ops until both operands arrive from the CDBs,
// then dispatches one per cycle on registered EX outputs. RS_AGE_SELECT_EN selects oldest-first dispatch.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE = DEF_RS_SIZE,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clr_in,
  input  logic               iss_valid,
  input  logic [ORDER_W-1:0] iss_order,
  input  logic [DATA_W-1:0]  iss_vj,
  input  logic [DATA_W-1:0]  iss_vk,
  input  logic               iss_qj_busy,
  input  logic               iss_qk_busy,
  input  logic [TAG_W-1:0]   iss_qj,
  input  logic [TAG_W-1:0]   iss_qk,
  input  logic [DATA_W-1:0]  iss_A,
  input  logic [DATA_W-1:0]  iss_pc,
  input  logic [TAG_W-1:0]   iss_dest,
  output logic               rs_full,
  input  logic               alu_cdb_valid,
  input  logic [TAG_W-1:0]   alu_cdb_tag,
  input  logic [DATA_W-1:0]  alu_cdb_val,
  input  logic               lsb_cdb_valid,
  input  logic [TAG_W-1:0]   lsb_cdb_tag,
  input  logic [DATA_W-1:0]  lsb_cdb_val,
  output logic               ex_valid,
  output logic [ORDER_W-1:0] ex_order,
  output logic [DATA_W-1:0]  ex_vj,
  output logic [DATA_W-1:0]  ex_vk,
  output logic [DATA_W-1:0]  ex_A,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [TAG_W-1:0]   ex_dest
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [RS_SIZE-1:0] qk_busy;
  logic [ORDER_W-1:0] e_order [RS_SIZE];
  logic [DATA_W-1:0]  e_vj    [RS_SIZE];
  logic [DATA_W-1:0]  e_vk    [RS_SIZE];
  logic [TAG_W-1:0]   e_qj    [RS_SIZE];
  logic [TAG_W-1:0]   e_qk    [RS_SIZE];
  logic [DATA_W-1:0]  e_a     [RS_SIZE];
  logic [DATA_W-1:0]  e_pc    [RS_SIZE];
  logic [TAG_W-1:0]   e_dest  [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic [IDX_W-1:0]   free_idx;
  logic               free_found;
  logic [IDX_W-1:0]   disp_idx;
  logic               disp_found;
  logic               issue_fire;

  logic [DATA_W-1:0]  new_vj;
  logic [DATA_W-1:0]  new_vk;
  logic               new_qj_busy;
  logic               new_qk_busy;

  // Issue handshake: iss_valid is taken on a clk_in edge with rdy_in=1, clr_in=0 and rs_full=0;
  // any other request is dropped and the issue stage must hold it until rs_full falls.
  assign rs_full    = &busy;
  assign ready      = busy & ~qj_busy & ~qk_busy;
  assign issue_fire = iss_valid && free_found;

`ifdef RS_AGE_SELECT_EN
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age;

  // A new entry is younger than every entry already resident.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      age <= '0;
    end else if (rdy_in) begin
      if (clr_in) begin
        age <= '0;
      end else if (issue_fire) begin
        for (int j = 0; j < RS_SIZE; j++) begin
          age[free_idx][j] <= 1'b0;
          age[j][free_idx] <= busy[j];
        end
      end
    end
  end
`endif

  rs_alu_select #(
    .RS_SIZE (RS_SIZE),
    .IDX_W   (IDX_W)
  ) u_select (
    .busy       (busy),
    .ready      (ready),
`ifdef RS_AGE_SELECT_EN
    .age        (age),
`endif
    .free_idx   (free_idx),
    .free_found (free_found),
    .disp_idx   (disp_idx),
    .disp_found (disp_found)
  );

  // Operands broadcast in the issue cycle are captured directly; the ALU CDB has priority.
  always_comb begin
    new_vj      = iss_vj;
    new_qj_busy = iss_qj_busy;
    new_vk      = iss_vk;
    new_qk_busy = iss_qk_busy;
    if (iss_qj_busy) begin
      if (alu_cdb_valid && alu_cdb_tag == iss_qj) begin
        new_vj      = alu_cdb_val;
        new_qj_busy = 1'b0;
      end else if (lsb_cdb_valid && lsb_cdb_tag == iss_qj) begin
        new_vj      = lsb_cdb_val;
        new_qj_busy = 1'b0;
      end
    end
    if (iss_qk_busy) begin
      if (alu_cdb_valid && alu_cdb_tag == iss_qk) begin
        new_vk      = alu_cdb_val;
        new_qk_busy = 1'b0;
      end else if (lsb_cdb_valid && lsb_cdb_tag == iss_qk) begin
        new_vk      = lsb_cdb_val;
        new_qk_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy     <= '0;
      qj_busy  <= '0;
      qk_busy  <= '0;
      ex_valid <= 1'b0;
      ex_order <= '0;
      ex_vj    <= '0;
      ex_vk    <= '0;
      ex_A     <= '0;
      ex_pc    <= '0;
      ex_dest  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        e_order[i] <= '0;
        e_vj[i]    <= '0;
        e_vk[i]    <= '0;
        e_qj[i]    <= '0;
        e_qk[i]    <= '0;
        e_a[i]     <= '0;
        e_pc[i]    <= '0;
        e_dest[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (clr_in) begin
        busy     <= '0;
        ex_valid <= 1'b0;
      end else begin
        // Wakeup only touches still-pending operands, so it never races the dispatched entry.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && qj_busy[i]) begin
            if (alu_cdb_valid && alu_cdb_tag == e_qj[i]) begin
              e_vj[i]    <= alu_cdb_val;
              qj_busy[i] <= 1'b0;
            end else if (lsb_cdb_valid && lsb_cdb_tag == e_qj[i]) begin
              e_vj[i]    <= lsb_cdb_val;
              qj_busy[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_busy[i]) begin
            if (alu_cdb_valid && alu_cdb_tag == e_qk[i]) begin
              e_vk[i]    <= alu_cdb_val;
              qk_busy[i] <= 1'b0;
            end else if (lsb_cdb_valid && lsb_cdb_tag == e_qk[i]) begin
              e_vk[i]    <= lsb_cdb_val;
              qk_busy[i] <= 1'b0;
            end
          end
        end

        if (disp_found) begin
          busy[disp_idx] <= 1'b0;
          ex_valid       <= 1'b1;
          ex_order       <= e_order[disp_idx];
          ex_vj          <= e_vj[disp_idx];
          ex_vk          <= e_vk[disp_idx];
          ex_A           <= e_a[disp_idx];
          ex_pc          <= e_pc[disp_idx];
          ex_dest        <= e_dest[disp_idx];
        end else begin
          ex_valid <= 1'b0;
        end

        // The free slot is never busy, so it cannot coincide with the dispatched or woken entries.
        if (issue_fire) begin
          busy[free_idx]    <= 1'b1;
          e_order[free_idx] <= iss_order;
          e_vj[free_idx]    <= new_vj;
          e_vk[free_idx]    <= new_vk;
          qj_busy[free_idx] <= new_qj_busy;
          qk_busy[free_idx] <= new_qk_busy;
          e_qj[free_idx]    <= iss_qj;
          e_qk[free_idx]    <= iss_qk;
          e_a[free_idx]     <= iss_A;
          e_pc[free_idx]    <= iss_pc;
          e_dest[free_idx]  <= iss_dest;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios plus randomized traffic against a
// transaction-level reservation-station model and an expected-dispatch queue.
module tb_rs_alu;
  import rs_alu_pkg::*;

  localparam int RS    = 8;
  localparam int TW    = 4;
  localparam int PKT_W = 6 + 32 * 4 + TW;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clr_in;
  logic          iss_valid;
  logic [5:0]    iss_order;
  logic [31:0]   iss_vj, iss_vk;
  logic          iss_qj_busy, iss_qk_busy;
  logic [TW-1:0] iss_qj, iss_qk;
  logic [31:0]   iss_A, iss_pc;
  logic [TW-1:0] iss_dest;
  logic          rs_full;
  logic          alu_cdb_valid, lsb_cdb_valid;
  logic [TW-1:0] alu_cdb_tag, lsb_cdb_tag;
  logic [31:0]   alu_cdb_val, lsb_cdb_val;
  logic          ex_valid;
  logic [5:0]    ex_order;
  logic [31:0]   ex_vj, ex_vk, ex_A, ex_pc;
  logic [TW-1:0] ex_dest;

  rs_alu #(.RS_SIZE(RS), .TAG_W(TW)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clr_in        (clr_in),
    .iss_valid     (iss_valid),
    .iss_order     (iss_order),
    .iss_vj        (iss_vj),
    .iss_vk        (iss_vk),
    .iss_qj_busy   (iss_qj_busy),
    .iss_qk_busy   (iss_qk_busy),
    .iss_qj        (iss_qj),
    .iss_qk        (iss_qk),
    .iss_A         (iss_A),
    .iss_pc        (iss_pc),
    .iss_dest      (iss_dest),
    .rs_full       (rs_full),
    .alu_cdb_valid (alu_cdb_valid),
    .alu_cdb_tag   (alu_cdb_tag),
    .alu_cdb_val   (alu_cdb_val),
    .lsb_cdb_valid (lsb_cdb_valid),
    .lsb_cdb_tag   (lsb_cdb_tag),
    .lsb_cdb_val   (lsb_cdb_val),
    .ex_valid      (ex_valid),
    .ex_order      (ex_order),
    .ex_vj         (ex_vj),
    .ex_vk         (ex_vk),
    .ex_A          (ex_A),
    .ex_pc         (ex_pc),
    .ex_dest       (ex_dest)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  typedef struct {
    bit            busy;
    logic [5:0]    order;
    logic [31:0]   vj, vk, a, pc;
    bit            qjb, qkb;
    logic [TW-1:0] qj, qk, dest;
    int            seq;
  } ent_t;

  ent_t             m [RS];
  bit               m_ex_valid;
  logic [PKT_W-1:0] m_last;
  logic [PKT_W-1:0] exp_q [$];
  int               seq_cnt;
  int               n_tests;
  int               n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RS; i++) begin
      m[i].busy = 1'b0;
      m[i].qjb  = 1'b0;
      m[i].qkb  = 1'b0;
      m[i].seq  = 0;
    end
    m_ex_valid = 1'b0;
    m_last     = '0;
    seq_cnt    = 0;
    exp_q.delete();
  endtask

  function automatic bit model_full();
    for (int i = 0; i < RS; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit cdb_lookup(input logic [TW-1:0] tag, output logic [31:0] val);
    val = '0;
    if (alu_cdb_valid && alu_cdb_tag == tag) begin
      val = alu_cdb_val;
      return 1'b1;
    end
    if (lsb_cdb_valid && lsb_cdb_tag == tag) begin
      val = lsb_cdb_val;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    ent_t        nx [RS];
    int          sel, fr;
    logic [31:0] v;
    if (!rdy_in) return;
    if (clr_in) begin
      for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
      m_ex_valid = 1'b0;
      return;
    end
    sel = -1;
    for (int i = 0; i < RS; i++) begin
      if (m[i].busy && !m[i].qjb && !m[i].qkb) begin
`ifdef RS_AGE_SELECT_EN
        if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    fr = -1;
    for (int i = RS - 1; i >= 0; i--) if (!m[i].busy) fr = i;
    nx = m;
    for (int i = 0; i < RS; i++) begin
      if (m[i].busy && m[i].qjb && cdb_lookup(m[i].qj, v)) begin
        nx[i].vj  = v;
        nx[i].qjb = 1'b0;
      end
      if (m[i].busy && m[i].qkb && cdb_lookup(m[i].qk, v)) begin
        nx[i].vk  = v;
        nx[i].qkb = 1'b0;
      end
    end
    if (sel >= 0) begin
      m_last = {m[sel].order, m[sel].vj, m[sel].vk, m[sel].a, m[sel].pc, m[sel].dest};
      exp_q.push_back(m_last);
      nx[sel].busy = 1'b0;
      m_ex_valid   = 1'b1;
    end else begin
      m_ex_valid = 1'b0;
    end
    if (iss_valid && fr >= 0) begin
      nx[fr].busy  = 1'b1;
      nx[fr].order = iss_order;
      nx[fr].vj    = iss_vj;
      nx[fr].vk    = iss_vk;
      nx[fr].qjb   = iss_qj_busy;
      nx[fr].qkb   = iss_qk_busy;
      nx[fr].qj    = iss_qj;
      nx[fr].qk    = iss_qk;
      nx[fr].a     = iss_A;
      nx[fr].pc    = iss_pc;
      nx[fr].dest  = iss_dest;
      nx[fr].seq   = seq_cnt;
      seq_cnt++;
      if (iss_qj_busy && cdb_lookup(iss_qj, v)) begin
        nx[fr].vj  = v;
        nx[fr].qjb = 1'b0;
      end
      if (iss_qk_busy && cdb_lookup(iss_qk, v)) begin
        nx[fr].vk  = v;
        nx[fr].qkb = 1'b0;
      end
    end
    m = nx;
  endtask

  // ---------------- scoreboard ----------------
  task automatic scoreboard(input bit adv);
    logic [PKT_W-1:0] p;
    check("rs_full", rs_full, model_full());
    check("ex_valid", ex_valid, m_ex_valid);
    if (adv && ex_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_dispatch", 32'(exp_q.size()), 32'd1);
      end else begin
        p = exp_q.pop_front();
        check("q_order", ex_order, p[PKT_W-1 -: 6]);
        check("q_vj",    ex_vj,    p[TW+127 -: 32]);
        check("q_vk",    ex_vk,    p[TW+95 -: 32]);
        check("q_A",     ex_A,     p[TW+63 -: 32]);
        check("q_pc",    ex_pc,    p[TW+31 -: 32]);
        check("q_dest",  ex_dest,  p[TW-1:0]);
      end
    end
    check("hold_order", ex_order, m_last[PKT_W-1 -: 6]);
    check("hold_vj",    ex_vj,    m_last[TW+127 -: 32]);
    check("hold_dest",  ex_dest,  m_last[TW-1:0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rdy_in        = 1'b1;
    clr_in        = 1'b0;
    iss_valid     = 1'b0;
    iss_order     = '0;
    iss_vj        = '0;
    iss_vk        = '0;
    iss_qj_busy   = 1'b0;
    iss_qk_busy   = 1'b0;
    iss_qj        = '0;
    iss_qk        = '0;
    iss_A         = '0;
    iss_pc        = '0;
    iss_dest      = '0;
    alu_cdb_valid = 1'b0;
    alu_cdb_tag   = '0;
    alu_cdb_val   = '0;
    lsb_cdb_valid = 1'b0;
    lsb_cdb_tag   = '0;
    lsb_cdb_val   = '0;
  endtask

  task automatic drive_issue(input logic [5:0] order, input logic [31:0] vj, input logic [31:0] vk,
                             input logic qjb, input logic [TW-1:0] qj,
                             input logic qkb, input logic [TW-1:0] qk,
                             input logic [31:0] a, input logic [TW-1:0] dest);
    iss_valid   = 1'b1;
    iss_order   = order;
    iss_vj      = vj;
    iss_vk      = vk;
    iss_qj_busy = qjb;
    iss_qj      = qj;
    iss_qk_busy = qkb;
    iss_qk      = qk;
    iss_A       = a;
    iss_pc      = 32'h1000 + {28'd0, dest};
    iss_dest    = dest;
  endtask

  task automatic drive_alu_cdb(input logic [TW-1:0] tag, input logic [31:0] val);
    alu_cdb_valid = 1'b1;
    alu_cdb_tag   = tag;
    alu_cdb_val   = val;
  endtask

  task automatic drive_lsb_cdb(input logic [TW-1:0] tag, input logic [31:0] val);
    lsb_cdb_valid = 1'b1;
    lsb_cdb_tag   = tag;
    lsb_cdb_val   = val;
  endtask

  // One clock: model advances with current inputs, DUT sampled 1 time unit after the edge.
  task automatic step();
    bit adv;
    adv = rdy_in;
    model_step();
    @(posedge clk_in);
    #1;
    scoreboard(adv);
    drive_idle();
  endtask

  task automatic issue_pending_six(input logic [TW-1:0] dest_base);
    for (int i = 0; i < 6; i++) begin
      drive_issue(OP_ADD, 32'(i), 32'd2, 1'b1, TW'(i + 1), 1'b0, '0, '0, dest_base + TW'(i));
      step();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive_idle();
    rst_in = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_ex_valid", ex_valid, 0);
    check("reset_rs_full", rs_full, 0);
    check("reset_ex_dest", ex_dest, 0);
    check("reset_ex_vj", ex_vj, 0);
    rst_in = 1'b0;

    // Ready issue: EX valid two cycles later.
    drive_issue(OP_ADD, 32'd5, 32'd7, 1'b0, '0, 1'b0, '0, '0, 4'd3);
    step();
    step();
    check("ready_valid", ex_valid, 1);
    check("ready_order", ex_order, OP_ADD);
    check("ready_vj", ex_vj, 32'd5);
    check("ready_vk", ex_vk, 32'd7);
    check("ready_dest", ex_dest, 32'd3);

    // Wakeup through the ALU CDB in cycle 4, dispatch visible in cycle 6.
    drive_issue(OP_ADDI, 32'd0, 32'd0, 1'b1, 4'd9, 1'b0, '0, 32'd16, 4'd4);
    step();
    repeat (3) step();
    drive_alu_cdb(4'd9, 32'h100);
    step();
    step();
    check("wake_valid", ex_valid, 1);
    check("wake_vj", ex_vj, 32'h100);
    check("wake_A", ex_A, 32'd16);

    // Issue-time bypass from the LSB CDB, then ALU priority when both carry the tag.
    drive_issue(OP_SUB, 32'd9, 32'd0, 1'b0, '0, 1'b1, 4'd2, '0, 4'd5);
    drive_lsb_cdb(4'd2, 32'd40);
    step();
    step();
    check("bypass_lsb_vk", ex_vk, 32'd40);
    drive_issue(OP_SUB, 32'd9, 32'd0, 1'b0, '0, 1'b1, 4'd2, '0, 4'd6);
    drive_alu_cdb(4'd2, 32'd1);
    drive_lsb_cdb(4'd2, 32'd40);
    step();
    step();
    check("bypass_both_vk", ex_vk, 32'd1);

    // Fill all entries with pending operands.
    for (int i = 0; i < RS; i++) begin
      drive_issue(OP_XOR, 32'd0, 32'(i), 1'b1, TW'(i + 8), 1'b0, '0, '0, TW'(i));
      step();
    end
    check("full_set", rs_full, 1);
    drive_issue(OP_OR, 32'd1, 32'd1, 1'b0, '0, 1'b0, '0, '0, 4'd15);
    step();
    check("full_ignored", rs_full, 1);
    drive_alu_cdb(4'd11, 32'hABCD);
    step();
    step();
    check("full_drain_dest", ex_dest, 32'd3);
    check("full_cleared", rs_full, 0);
    drive_issue(OP_AND, 32'd3, 32'd4, 1'b0, '0, 1'b0, '0, '0, 4'd13);
    step();
    check("full_refill", rs_full, 1);
    step();
    check("refill_dest", ex_dest, 32'd13);
    clr_in = 1'b1;
    step();

    // Entries 1 and 5 become ready together, then flush.
    issue_pending_six(4'd0);
    drive_alu_cdb(4'd2, 32'h11);
    drive_lsb_cdb(4'd6, 32'h55);
    step();
    clr_in = 1'b1;
    step();
    check("flush_ex_valid", ex_valid, 0);
    step();
    check("flush_gone", ex_valid, 0);

    // Same setup without the flush: lowest index goes first.
    issue_pending_six(4'd0);
    drive_alu_cdb(4'd2, 32'h11);
    drive_lsb_cdb(4'd6, 32'h55);
    step();
    step();
    check("order_first", ex_dest, 32'd1);
    step();
    check("order_second", ex_dest, 32'd5);
    clr_in = 1'b1;
    step();

    // Slot 1 re-issued after slot 5, both woken together.
    issue_pending_six(4'd8);
    drive_alu_cdb(4'd2, 32'h22);
    step();
    step();
    check("age_prep_dest", ex_dest, 32'd9);
    drive_issue(OP_SLT, 32'd0, 32'd1, 1'b1, 4'd9, 1'b0, '0, '0, 4'd7);
    step();
    drive_alu_cdb(4'd9, 32'h99);
    drive_lsb_cdb(4'd6, 32'h66);
    step();
    step();
`ifdef RS_AGE_SELECT_EN
    check("age_first", ex_dest, 32'd13);
`else
    check("age_first", ex_dest, 32'd7);
`endif
    step();
    clr_in = 1'b1;
    step();

    // Asynchronous reset with three entries resident and a dispatch in flight.
    for (int i = 0; i < 3; i++) begin
      drive_issue(OP_ADD, 32'd1, 32'd1, 1'b1, TW'(i + 1), 1'b0, '0, '0, TW'(i));
      step();
    end
    drive_issue(OP_ADD, 32'd1, 32'd1, 1'b0, '0, 1'b0, '0, '0, 4'd12);
    step();
    step();
    check("pre_reset_ex_valid", ex_valid, 1);
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_ex_valid", ex_valid, 0);
    check("async_rst_full", rs_full, 0);
    check("async_rst_dest", ex_dest, 0);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    drive_alu_cdb(4'd1, 32'h5);
    step();
    repeat (2) step();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      clr_in = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) < 6)
        drive_issue(6'($urandom_range(1, 37)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)),
                    $urandom, TW'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) drive_alu_cdb(TW'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 1) == 1) drive_lsb_cdb(TW'($urandom_range(0, 15)), $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
